// File: rtl/minhash_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// minhash_pkg : shared sizes and scheduler state encoding for the minhash block
// Revision 1.0
// ---------------------------------------------------------------------------
package minhash_pkg;

   localparam int NUM_HASH = 16;
   localparam int COEF_W   = 32;
   localparam int SIM_W    = 5;
   localparam int IDX_W    = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/minhash_coef_table.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// minhash_coef_table : NUM_HASH x (A,B) coefficient register file, one write
// port, one asynchronous read port. Revision 1.0
// ---------------------------------------------------------------------------
module minhash_coef_table #(
   parameter int NUM_HASH = 16,
   parameter int COEF_W   = 32
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              wr_en,
   input  logic [4:0]        wr_addr,
   input  logic [COEF_W-1:0] wr_a,
   input  logic [COEF_W-1:0] wr_b,
   input  logic [4:0]        rd_addr,
   output logic [COEF_W-1:0] rd_a,
   output logic [COEF_W-1:0] rd_b
);

   logic [COEF_W-1:0] mem_a [NUM_HASH];
   logic [COEF_W-1:0] mem_b [NUM_HASH];

   // Address decode by comparison: out-of-range writes match no entry.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_HASH; i++) begin
         if (rstN) begin
            mem_a[i] <= '0;
            mem_b[i] <= '0;
         end else if (wr_en && (wr_addr == 5'(i))) begin
            mem_a[i] <= wr_a;
            mem_b[i] <= wr_b;
         end
      end
   end

   always_comb begin
      rd_a = '0;
      rd_b = '0;
      for (int i = 0; i < NUM_HASH; i++) begin
         if (rd_addr == 5'(i)) begin
            rd_a = mem_a[i];
            rd_b = mem_b[i];
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/minhash_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// minhash_scheduler : issues hash-coefficient pairs to the minhash datapath and
// counts matching results into a Jaccard similarity score. Revision 1.0
// ---------------------------------------------------------------------------
module minhash_scheduler #(
   parameter int NUM_HASH = minhash_pkg::NUM_HASH,
   parameter int COEF_W   = minhash_pkg::COEF_W
) (
   input  logic                          clk,
   input  logic                          rstN,
   input  logic                          start,
   input  logic                          coefWrEn,
   input  logic [4:0]                    coefWrAddr,
   input  logic [COEF_W-1:0]             coefWrA,
   input  logic [COEF_W-1:0]             coefWrB,
   output logic [COEF_W-1:0]             randA,
   output logic [COEF_W-1:0]             randB,
   output logic                          hashValid,
   input  logic                          dpReady,
   input  logic                          matchValid,
   input  logic                          matchBit,
   output logic                          busy,
   output logic                          done,
   output logic [minhash_pkg::SIM_W-1:0] jaccardSimilarity
);
   import minhash_pkg::*;

   localparam logic [4:0] LAST_IDX = 5'(NUM_HASH - 1);
   localparam logic [4:0] NUM_U    = 5'(NUM_HASH);

   state_t            state;
   logic [4:0]        issue_idx;
   logic [4:0]        result_cnt;
   logic [SIM_W-1:0]  match_cnt;
   logic [4:0]        rd_addr;
   logic [COEF_W-1:0] rd_a;
   logic [COEF_W-1:0] rd_b;
   logic              issue;
   logic              count_result;
   logic              table_wr;
   logic [SIM_W-1:0]  match_next;

   // The read port looks one entry ahead so the next pair is ready on issue.
   assign rd_addr      = (state == ST_IDLE) ? 5'd0 : issue_idx + 5'd1;
   assign issue        = hashValid && dpReady;
   assign count_result = matchValid && ((state == ST_ISSUE) || (state == ST_WAIT))
                         && (result_cnt < NUM_U);
   assign table_wr     = coefWrEn && (state == ST_IDLE);
   assign match_next   = match_cnt + {{(SIM_W-1){1'b0}}, matchBit};

   minhash_coef_table #(
      .NUM_HASH (NUM_HASH),
      .COEF_W   (COEF_W)
   ) u_table (
      .clk     (clk),
      .rstN    (rstN),
      .wr_en   (table_wr),
      .wr_addr (coefWrAddr),
      .wr_a    (coefWrA),
      .wr_b    (coefWrB),
      .rd_addr (rd_addr),
      .rd_a    (rd_a),
      .rd_b    (rd_b)
   );

   always_ff @(posedge clk) begin
      if (rstN) begin
         state             <= ST_IDLE;
         issue_idx         <= '0;
         result_cnt        <= '0;
         match_cnt         <= '0;
         randA             <= '0;
         randB             <= '0;
         hashValid         <= 1'b0;
         busy              <= 1'b0;
         done              <= 1'b0;
         jaccardSimilarity <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_ISSUE;
                  busy       <= 1'b1;
                  hashValid  <= 1'b1;
                  randA      <= rd_a;
                  randB      <= rd_b;
                  issue_idx  <= '0;
                  result_cnt <= '0;
                  match_cnt  <= '0;
               end
            end
            ST_ISSUE, ST_WAIT: begin
               if (issue) begin
                  if (issue_idx == LAST_IDX) begin
                     hashValid <= 1'b0;
                     state     <= ST_WAIT;
                  end else begin
                     issue_idx <= issue_idx + 5'd1;
                     randA     <= rd_a;
                     randB     <= rd_b;
                  end
               end
               // Completion wins over the ISSUE->WAIT move on the same edge.
               if (count_result) begin
                  result_cnt <= result_cnt + 5'd1;
                  match_cnt  <= match_next;
                  if (result_cnt == LAST_IDX) begin
                     state             <= ST_DONE;
                     hashValid         <= 1'b0;
                     done              <= 1'b1;
                     jaccardSimilarity <= match_next;
                  end
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_minhash_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ---------------------------------------------------------------------------
// tb_minhash_scheduler : directed runs against a transaction-level model of the
// scheduler, with an emulated datapath of latency 2. Revision 1.0
// ---------------------------------------------------------------------------
module tb_minhash_scheduler;

   localparam int N = 16;
   localparam int L = 2;

   logic        clk = 1'b0;
   logic        rstN;
   logic        start;
   logic        coefWrEn;
   logic [4:0]  coefWrAddr;
   logic [31:0] coefWrA;
   logic [31:0] coefWrB;
   logic [31:0] randA;
   logic [31:0] randB;
   logic        hashValid;
   logic        dpReady;
   logic        matchValid;
   logic        matchBit;
   logic        busy;
   logic        done;
   logic [4:0]  jaccardSimilarity;

   int n_checks = 0;
   int n_err    = 0;
   int cyc      = 0;

   bit sched_v [4096];
   bit sched_b [4096];
   int pattern;
   bit stall;
   bit extra;
   bit dp_auto;
   int dp_n;
   int issues_seen;

   logic [31:0] mt_a [N];
   logic [31:0] mt_b [N];
   bit          m_run, m_valid, m_done, model_on;
   int          m_issued, m_results, m_matches, m_sim;
   logic [31:0] m_a, m_b;

   minhash_scheduler #(.NUM_HASH(N), .COEF_W(32)) dut (
      .clk               (clk),
      .rstN              (rstN),
      .start             (start),
      .coefWrEn          (coefWrEn),
      .coefWrAddr        (coefWrAddr),
      .coefWrA           (coefWrA),
      .coefWrB           (coefWrB),
      .randA             (randA),
      .randB             (randB),
      .hashValid         (hashValid),
      .dpReady           (dpReady),
      .matchValid        (matchValid),
      .matchBit          (matchBit),
      .busy              (busy),
      .done              (done),
      .jaccardSimilarity (jaccardSimilarity)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] tbl_a(input int i);
      if (i == 0) return 32'd10323;
      if (i == 7) return 32'd1441;
      return 32'(1000 + 37 * i);
   endfunction

   function automatic logic [31:0] tbl_b(input int i);
      if (i == 0) return 32'd10091;
      if (i == 7) return 32'd1091;
      return 32'(2000 + 53 * i);
   endfunction

   function automatic bit pat_bit(input int p, input int n);
      if (p == 0) return 1'b1;
      if (p == 1) return 1'b0;
      return (n % 2) == 0;
   endfunction

   // Transaction-level model: advances on the inputs seen during one cycle.
   task automatic model_step();
      if (rstN) begin
         m_run = 0; m_valid = 0; m_done = 0;
         m_issued = 0; m_results = 0; m_matches = 0; m_sim = 0;
         m_a = '0; m_b = '0;
         for (int i = 0; i < N; i++) begin
            mt_a[i] = '0;
            mt_b[i] = '0;
         end
      end else if (m_done) begin
         m_done = 0;
         m_run  = 0;
      end else if (!m_run) begin
         if (start) begin
            m_run = 1; m_valid = 1;
            m_issued = 0; m_results = 0; m_matches = 0;
            m_a = mt_a[0]; m_b = mt_b[0];
         end
         if (coefWrEn && int'(coefWrAddr) < N) begin
            mt_a[coefWrAddr] = coefWrA;
            mt_b[coefWrAddr] = coefWrB;
         end
      end else begin
         if (m_valid && dpReady) begin
            m_issued++;
            if (m_issued == N) m_valid = 0;
            else begin
               m_a = mt_a[m_issued];
               m_b = mt_b[m_issued];
            end
         end
         if (matchValid && m_results < N) begin
            m_results++;
            if (matchBit) m_matches++;
            if (m_results == N) begin
               m_done = 1;
               m_valid = 0;
               m_sim = m_matches;
            end
         end
      end
   endtask

   // Compare process plus datapath emulation, on the falling edge.
   initial forever begin
      @(negedge clk);
      if (model_on) begin
         check("hashValid", {63'd0, hashValid}, {63'd0, m_valid});
         check("busy", {63'd0, busy}, {63'd0, m_run});
         check("done", {63'd0, done}, {63'd0, m_done});
         check("randA", {32'd0, randA}, {32'd0, m_a});
         check("randB", {32'd0, randB}, {32'd0, m_b});
         check("jaccard", {59'd0, jaccardSimilarity}, 64'(m_sim));
      end
      if (hashValid === 1'b1 && dpReady) begin
         issues_seen++;
         sched_v[cyc + L] = 1'b1;
         sched_b[cyc + L] = pat_bit(pattern, dp_n);
         if (extra && dp_n == N - 1) begin
            sched_v[cyc + L + 1] = 1'b1;
            sched_b[cyc + L + 1] = 1'b1;
         end
         dp_n++;
      end
      model_step();
      model_on = 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (dp_auto) begin
         matchValid = sched_v[cyc];
         matchBit   = sched_b[cyc];
      end
      if (stall) dpReady = (cyc % 2) == 1;
   endtask

   task automatic load();
      for (int i = 0; i < N; i++) begin
         coefWrEn = 1'b1; coefWrAddr = 5'(i); coefWrA = tbl_a(i); coefWrB = tbl_b(i);
         tick();
      end
      coefWrEn = 1'b1; coefWrAddr = 5'd20; coefWrA = 32'hFFFF; coefWrB = 32'hFFFF;
      tick();
      coefWrEn = 1'b0;
      tick();
   endtask

   task automatic run(input int p, input bit stl, input bit ext, input bit poke,
                      input int pin_idx, input logic [31:0] pa, input logic [31:0] pb,
                      input int exp_sim, input string tag);
      int s;
      int k;
      pattern = p; stall = stl; extra = ext; dp_auto = 1'b1;
      dp_n = 0; issues_seen = 0;
      if (!stl) dpReady = 1'b1;
      start = 1'b1;
      s = cyc;
      tick();
      start = 1'b0;
      check({tag, "_first_a"}, {32'd0, randA}, 64'd10323);
      check({tag, "_first_b"}, {32'd0, randB}, 64'd10091);
      if (pin_idx >= 0) begin
         while (cyc < s + 1 + pin_idx) tick();
         check({tag, "_pin_a"}, {32'd0, randA}, {32'd0, pa});
         check({tag, "_pin_b"}, {32'd0, randB}, {32'd0, pb});
      end
      k = 0;
      while (done !== 1'b1 && k < 200) begin
         tick();
         k++;
         if (poke && cyc == s + 17) begin
            start = 1'b1; coefWrEn = 1'b1; coefWrAddr = 5'd3;
            coefWrA = 32'hDEAD; coefWrB = 32'hBEEF;
         end else begin
            start = 1'b0; coefWrEn = 1'b0;
         end
      end
      check({tag, "_done_seen"}, {63'd0, done}, 64'd1);
      if (!stl) check({tag, "_latency"}, 64'(cyc - s), 64'(N + L + 1));
      check({tag, "_sim"}, {59'd0, jaccardSimilarity}, 64'(exp_sim));
      repeat (3) tick();
      check({tag, "_issues"}, 64'(issues_seen), 64'(N));
      stall = 1'b0;
      dpReady = 1'b1;
   endtask

   initial begin
      int s;
      rstN = 1'b1; start = 1'b0; coefWrEn = 1'b0; coefWrAddr = '0;
      coefWrA = '0; coefWrB = '0; dpReady = 1'b1; matchValid = 1'b0; matchBit = 1'b0;
      pattern = 0; stall = 1'b0; extra = 1'b0; dp_auto = 1'b0; dp_n = 0; issues_seen = 0;
      tick();
      tick();
      rstN = 1'b0;
      tick();
      check("rst_hashValid", {63'd0, hashValid}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_randA", {32'd0, randA}, 64'd0);
      check("rst_jaccard", {59'd0, jaccardSimilarity}, 64'd0);

      load();
      run(0, 1'b0, 1'b1, 1'b0, 7, 32'd1441, 32'd1091, 16, "all_ones");

      dp_auto = 1'b0;
      matchValid = 1'b1;
      matchBit = 1'b1;
      repeat (4) begin
         tick();
         check("idle_mv_sim", {59'd0, jaccardSimilarity}, 64'd16);
         check("idle_mv_done", {63'd0, done}, 64'd0);
      end
      matchValid = 1'b0;
      matchBit = 1'b0;

      run(1, 1'b0, 1'b0, 1'b0, -1, 32'd0, 32'd0, 0, "all_zeros");
      run(2, 1'b1, 1'b0, 1'b0, -1, 32'd0, 32'd0, 8, "alt_stall");
      run(0, 1'b0, 1'b0, 1'b1, -1, 32'd0, 32'd0, 16, "wait_poke");
      run(1, 1'b0, 1'b0, 1'b0, 3, 32'd1111, 32'd2159, 0, "table3_kept");

      pattern = 0; extra = 1'b0; dp_auto = 1'b1; dp_n = 0; issues_seen = 0;
      run(0, 1'b0, 1'b0, 1'b0, -1, 32'd0, 32'd0, 16, "pre_abort");
      start = 1'b1;
      s = cyc;
      tick();
      start = 1'b0;
      while (cyc < s + 6) tick();
      rstN = 1'b1;
      tick();
      rstN = 1'b0;
      check("abort_hashValid", {63'd0, hashValid}, 64'd0);
      check("abort_busy", {63'd0, busy}, 64'd0);
      check("abort_randA", {32'd0, randA}, 64'd0);
      check("abort_jaccard", {59'd0, jaccardSimilarity}, 64'd0);
      repeat (25) begin
         tick();
         check("abort_no_done", {63'd0, done}, 64'd0);
      end

      load();
      run(2, 1'b0, 1'b0, 1'b0, -1, 32'd0, 32'd0, 8, "after_abort");

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

   initial begin
      #100000;
      n_err++;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $fatal(1);
   end

endmodule
`default_nettype wire
